// File: rtl/regfile_pkg.sv
//------------------------------------------------------------------------------
// Module   : regfile_pkg
// Brief    : Shared constants for the bypassing, scoreboarded register file.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package regfile_pkg;

    localparam int   c_default_data_w   = 10;
    localparam int   c_default_num_regs = 8;
    // Every register bit takes this value at reset.
    localparam logic c_reg_rst_bit      = 1'b0;
    localparam int   c_zero_reg         = 0;

endpackage : regfile_pkg

`default_nettype wire

// File: rtl/regfile_read_port.sv
//------------------------------------------------------------------------------
// Module   : regfile_read_port
// Brief    : One read port: address mux, write bypass and RAW hazard term.
//            Honours REGFILE_ZERO_REG_EN (register 0 hardwired to zero).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module regfile_read_port
    import regfile_pkg::*;
#(
    parameter  int DATA_W   = c_default_data_w,
    parameter  int NUM_REGS = c_default_num_regs,
    localparam int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic [DATA_W-1:0]   i_mem [NUM_REGS],
    input  logic [NUM_REGS-1:0] i_pending,
    input  logic                i_rst,
    input  logic                i_wr_en,
    input  logic [ADDR_W-1:0]   i_wr_dest,
    input  logic [DATA_W-1:0]   i_wr_data,
    input  logic [ADDR_W-1:0]   i_rd_addr,
    output logic [DATA_W-1:0]   o_rd_data,
    output logic                o_hazard
);

    logic w_bypass;

    // i_wr_en is already qualified by reset and by the zero-register drop.
    assign w_bypass = i_wr_en && (i_wr_dest == i_rd_addr);

    always_comb begin
        o_rd_data = w_bypass ? i_wr_data : i_mem[i_rd_addr];
`ifdef REGFILE_ZERO_REG_EN
        if (i_rd_addr == ADDR_W'(c_zero_reg)) begin
            o_rd_data = {DATA_W{c_reg_rst_bit}};
        end
`endif
    end

    assign o_hazard = ~i_rst & i_pending[i_rd_addr] & ~w_bypass;

endmodule : regfile_read_port

`default_nettype wire

// File: rtl/regfile_bypass_sb.sv
//------------------------------------------------------------------------------
// Module   : regfile_bypass_sb
// Brief    : Parametrised register file with same-cycle write bypass and a
//            pending-write scoreboard. Option: REGFILE_ZERO_REG_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module regfile_bypass_sb
    import regfile_pkg::*;
#(
    parameter  int DATA_W   = c_default_data_w,
    parameter  int NUM_REGS = c_default_num_regs,
    parameter  int NUM_RD   = 2,
    localparam int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     write_en,
    input  logic [ADDR_W-1:0]        reg_write_dest,
    input  logic [DATA_W-1:0]        write_data,
    input  logic [NUM_RD*ADDR_W-1:0] read_addr,
    output logic [NUM_RD*DATA_W-1:0] read_data,
    input  logic                     issue_en,
    input  logic [ADDR_W-1:0]        issue_dest,
    output logic [NUM_REGS-1:0]      pending,
    output logic [NUM_RD-1:0]        hazard
);

    logic [DATA_W-1:0]   r_mem [NUM_REGS];
    logic [NUM_REGS-1:0] r_pending;
    logic                w_wr_en;
    logic                w_iss_en;

`ifdef REGFILE_ZERO_REG_EN
    assign w_wr_en  = write_en & ~reset & (reg_write_dest != ADDR_W'(c_zero_reg));
    assign w_iss_en = issue_en & (issue_dest != ADDR_W'(c_zero_reg));
`else
    assign w_wr_en  = write_en & ~reset;
    assign w_iss_en = issue_en;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                r_mem[r] <= {DATA_W{c_reg_rst_bit}};
            end
            r_pending <= '0;
        end else begin
            if (w_wr_en) begin
                r_mem[reg_write_dest] <= write_data;
            end
            // Issue wins over writeback: the newer producer is still outstanding.
            for (int r = 0; r < NUM_REGS; r++) begin
                if (w_iss_en && (issue_dest == ADDR_W'(r))) begin
                    r_pending[r] <= 1'b1;
                end else if (w_wr_en && (reg_write_dest == ADDR_W'(r))) begin
                    r_pending[r] <= 1'b0;
                end
            end
        end
    end

    assign pending = r_pending;

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd_port
        regfile_read_port #(
            .DATA_W   (DATA_W),
            .NUM_REGS (NUM_REGS)
        ) u_rd_port (
            .i_mem     (r_mem),
            .i_pending (r_pending),
            .i_rst     (reset),
            .i_wr_en   (w_wr_en),
            .i_wr_dest (reg_write_dest),
            .i_wr_data (write_data),
            .i_rd_addr (read_addr[g*ADDR_W +: ADDR_W]),
            .o_rd_data (read_data[g*DATA_W +: DATA_W]),
            .o_hazard  (hazard[g])
        );
    end : g_rd_port

endmodule : regfile_bypass_sb

`default_nettype wire
